// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and counter-width helper.
// Used by the receiver today and intended for the transmitter as well.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Serial line, sample tick and character-completion bundle of the UART receiver.
interface uart_rx_core_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic                 i_rx;
    logic                 i_sample_tick;
    logic                 o_enq_rxq;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_frame_err;
    logic                 o_parity_err;
    logic                 o_busy;

    modport slave (
        input  i_rx,
        input  i_sample_tick,
        output o_enq_rxq,
        output o_data,
        output o_frame_err,
        output o_parity_err,
        output o_busy
    );

    modport master (
        output i_rx,
        output i_sample_tick,
        input  o_enq_rxq,
        input  o_data,
        input  o_frame_err,
        input  o_parity_err,
        input  o_busy
    );

endinterface

// File: rtl/uart_rx_core_sync.sv
// Two-flop synchroniser with a configurable reset value (serial RX, CTS).
module rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability filter: two flops in series.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receive engine: start validation, data/parity/stop
// sampling at bit centres, one-cycle enqueue pulse per character.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    uart_rx_core_if.slave  rx_if
);

    localparam int unsigned CW = cnt_width(OVERSAMPLE);
    localparam int unsigned BW = cnt_width(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = 1'(PARITY_ODD);

    uart_state_e          r_state,      w_state_nxt;
    logic [CW-1:0]        r_cnt,        w_cnt_nxt;
    logic [BW-1:0]        r_bitcnt,     w_bitcnt_nxt;
    logic [DATA_BITS-1:0] r_shift,      w_shift_nxt;
    logic                 r_armed,      w_armed_nxt;
    logic                 r_ferr,       w_ferr_nxt;
    logic                 r_perr,       w_perr_nxt;
    logic                 r_enq,        w_enq_nxt;
    logic [DATA_BITS-1:0] r_data,       w_data_nxt;
    logic                 r_frame_err,  w_frame_err_nxt;
    logic                 r_parity_err, w_parity_err_nxt;
    logic                 r_busy,       w_busy_nxt;

    logic w_rx_s;
    logic w_tick;
    logic w_at_last;
    logic w_stop_ferr;

    rx_sync #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (rx_if.i_rx),
        .o_q   (w_rx_s)
    );

    assign w_tick      = rx_if.i_sample_tick;
    assign w_at_last   = w_tick && (r_cnt == CNT_LAST);
    assign w_stop_ferr = r_ferr | ~w_rx_s;

    // Next-state, counter, datapath and output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_bitcnt_nxt     = r_bitcnt;
        w_shift_nxt      = r_shift;
        w_armed_nxt      = r_armed;
        w_ferr_nxt       = r_ferr;
        w_perr_nxt       = r_perr;
        w_enq_nxt        = 1'b0;
        w_data_nxt       = r_data;
        w_frame_err_nxt  = r_frame_err;
        w_parity_err_nxt = r_parity_err;

        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt    = '0;
                w_bitcnt_nxt = '0;
                if (w_rx_s) begin
                    w_armed_nxt = 1'b1;
                end else if (r_armed) begin
                    w_state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (w_tick) begin
                    if (r_cnt == CNT_HALF) begin
                        w_cnt_nxt    = '0;
                        w_bitcnt_nxt = '0;
                        if (!w_rx_s) begin
                            w_state_nxt = ST_DATA;
                            w_ferr_nxt  = 1'b0;
                            w_perr_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (w_tick) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                if (w_at_last) begin
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bitcnt == BIT_LAST) begin
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + BW'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (w_tick) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                if (w_at_last) begin
                    w_perr_nxt  = (^r_shift) ^ w_rx_s ^ PAR_ODD;
                    w_state_nxt = ST_STOP;
                end
            end

            ST_STOP: begin
                if (w_tick) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                if (w_at_last) begin
                    w_ferr_nxt = w_stop_ferr;
                    if (r_bitcnt == STOP_LAST) begin
                        w_state_nxt      = ST_IDLE;
                        w_cnt_nxt        = '0;
                        w_bitcnt_nxt     = '0;
                        w_enq_nxt        = 1'b1;
                        w_data_nxt       = r_shift;
                        w_frame_err_nxt  = w_stop_ferr;
                        w_parity_err_nxt = r_perr & PAR_EN;
                        // A broken frame must see idle-high before the next start.
                        if (w_stop_ferr) begin
                            w_armed_nxt = 1'b0;
                        end
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + BW'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, counters, datapath and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_armed      <= 1'b0;
            r_ferr       <= 1'b0;
            r_perr       <= 1'b0;
            r_enq        <= 1'b0;
            r_data       <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_shift      <= w_shift_nxt;
            r_armed      <= w_armed_nxt;
            r_ferr       <= w_ferr_nxt;
            r_perr       <= w_perr_nxt;
            r_enq        <= w_enq_nxt;
            r_data       <= w_data_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign rx_if.o_enq_rxq    = r_enq;
    assign rx_if.o_data       = r_data;
    assign rx_if.o_frame_err  = r_frame_err;
    assign rx_if.o_parity_err = r_parity_err;
    assign rx_if.o_busy       = r_busy;

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive engine, the successor to the fixed 8N1 receiver in the serial front end. It oversamples the line with an external baud tick and supports configurable data width, oversample ratio and stop-bit count. It rejects false starts, reports framing and parity errors, and pushes each completed character to the RX queue with a one-cycle valid pulse.

## Interface
- DATA_BITS, 8: character width, legal 5..9.
- OVERSAMPLE, 16: ticks per bit, power of two, ≥4.
- STOP_BITS, 1: stop bits checked, 1 or 2.
- PARITY_ODD, 0: 0 = even, 1 = odd. Used only when `UART_RX_PARITY_EN` is defined.
- i_clk  in  1  single clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx  in  1  serial line, asynchronous to i_clk, idle high.
- i_sample_tick  in  1  one-cycle pulse at OVERSAMPLE × baud.
- o_enq_rxq  out  1  one-cycle pulse when a character completes.
- o_data  out  DATA_BITS  last character, LSB first on the wire.
- o_frame_err  out  1  a stop bit of the last character sampled low.
- o_parity_err  out  1  parity mismatch on the last character.
- o_busy  out  1  high in every state except IDLE.

## Operation
- **Input synchroniser:** i_rx passes through a 2-flop synchroniser (flops reset to 1). All logic below uses the synchronised value rx_s.
- **Counters:** cycle counter is $clog2(OVERSAMPLE) bits and wraps naturally at OVERSAMPLE-1 → 0. Bit counter is $clog2(DATA_BITS+1) bits. Counters advance only on i_sample_tick.
- **IDLE:** r_armed is set whenever rx_s=1. If rx_s=0 and r_armed=1, go to START and clear the cycle counter.
- **START:** on the tick where count = OVERSAMPLE/2-1:
  - rx_s=0: go to DATA, clear both counters. This aligns all later samples to bit centres.
  - rx_s=1: false start; return to IDLE with no output.
- **DATA:** on the tick where count = OVERSAMPLE-1, shift rx_s into the MSB of the shift register (shift right). After DATA_BITS samples, go to PARITY if the macro is defined, otherwise to STOP.
- **PARITY:** sample at count = OVERSAMPLE-1. Latch parity_err = XOR(data bits, received bit) XOR PARITY_ODD, so 1 means error.
- **STOP:** sample at count = OVERSAMPLE-1 for each of STOP_BITS bits. Any low sample sets frame_err.
  - After the final stop sample, return to IDLE and clear the counters.
  - If frame_err is set, clear r_armed. The block does not re-arm until the line is seen high, which prevents a held-low break from producing a stream of characters.
- **Character completion:** on the final stop sample, register o_data, o_frame_err and o_parity_err, and pulse o_enq_rxq. The data is delivered even when an error flag is set.
- **Output hold:** outputs hold their values until the next completion.

## Timing
- **Reset values:** all outputs 0, state IDLE, counters 0, shift register 0, r_armed 0. An asynchronous assert mid-frame aborts the frame with no enqueue.
- **Synchroniser latency:** an i_rx edge is visible on rx_s 2 cycles later.
- **Completion latency:** o_enq_rxq rises in the cycle after the i_sample_tick that samples the final stop bit. It is high for exactly one cycle, and o_data/error flags are valid in the same cycle.
- **Frame duration:** start detect to enqueue is OVERSAMPLE/2 + (DATA_BITS + P + STOP_BITS)·OVERSAMPLE ticks (P = 1 with parity, else 0). The return to IDLE at mid-stop-bit gives half a bit of margin for back-to-back frames.
- **Tick without activity:** i_sample_tick in IDLE has no effect.
- **Ticks on consecutive cycles:** legal; each tick advances the counter once.
- **Downstream handshake:** none. The RX queue must accept every pulse, and overflow is the queue's concern.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, one parity bit is expected after the data bits, and o_parity_err is live.
- `UART_RX_PARITY_EN` undefined: there is no PARITY state, DATA goes directly to STOP, o_parity_err is tied 0, and PARITY_ODD is ignored.

## Structure
- **uart_pkg:** the state enum (IDLE, START, DATA, PARITY, STOP) and the localparam helper for counter widths. These are shared with the future transmitter.
- **Sub-module rx_sync:** the 2-flop synchroniser with parameterised reset value (here 1). It is reused for the CTS input.

## Test plan
- **8N1 default (DATA_BITS=8, OVERSAMPLE=16):** send 0xA5 → one o_enq_rxq pulse, o_data=0xA5, both error flags 0, o_busy low afterwards.
- **False start:** drive rx low for 4 ticks, then high → no enqueue, o_busy returns to 0 within OVERSAMPLE/2 ticks.
- **Framing error and break:** send 0x3C with stop bit low, then hold rx low → one pulse with o_data=0x3C and o_frame_err=1. No further pulses until rx returns high, after which the next frame is received normally.
- **Parity error (macro defined, even parity):** send 0x07 with parity bit 0 → o_parity_err=1. Resend with parity bit 1 → o_parity_err=0.
- **Back-to-back frames (DATA_BITS=7, STOP_BITS=2, OVERSAMPLE=8):** send 0x00 then 0x7F with no idle gap → two pulses, with data 0x00 then 0x7F and no errors.
- **Reset mid-frame:** assert i_rst during the 4th data bit → all outputs 0 immediately with no enqueue. After release, send 0x5A → received correctly.
